exc_ctrl: RTL and testbench

//  Exception/interrupt sequencer between WB stage and cp0. Detects exceptions, ERET and pending interrupts on the

---
 rtl/exc_ctrl_pkg.sv | 54 +++++
 rtl/exc_ctrl_select.sv | 55 +++++
 rtl/exc_ctrl.sv | 158 +++++++++++++++
 tb/tb_exc_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// ============================================================================
// Module      : exc_ctrl_pkg
// Description : Shared definitions for the exception/interrupt sequencer:
//               excodes, FSM state encodings, event kinds, default vector and
//               the captured-event record.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package exc_ctrl_pkg;

  // Excodes used by the pipeline
  localparam logic [4:0] EX_INT  = 5'h00;
  localparam logic [4:0] EX_ADEL = 5'h04;
  localparam logic [4:0] EX_ADES = 5'h05;
  localparam logic [4:0] EX_SYS  = 5'h08;
  localparam logic [4:0] EX_BP   = 5'h09;
  localparam logic [4:0] EX_RI   = 5'h0a;
  localparam logic [4:0] EX_OV   = 5'h0c;

  // Sequencer state encodings
  localparam logic [1:0] EXC_ST_IDLE     = 2'd0;
  localparam logic [1:0] EXC_ST_COMMIT   = 2'd1;
  localparam logic [1:0] EXC_ST_FLUSH    = 2'd2;
  localparam logic [1:0] EXC_ST_REDIRECT = 2'd3;

  // Kind of captured event
  localparam logic [1:0] EXC_KIND_INT  = 2'd0;
  localparam logic [1:0] EXC_KIND_EX   = 2'd1;
  localparam logic [1:0] EXC_KIND_ERET = 2'd2;

  // Exception/interrupt entry PC with BEV=1
  localparam logic [31:0] EXC_VECTOR = 32'hbfc0_0380;

  typedef struct packed {
    logic [1:0]  kind;
    logic [4:0]  excode;
    logic        bd;
    logic [31:0] pc;
    logic [31:0] badvaddr;
  } exc_event_t;

  // Interrupt is taken only when globally enabled, not already in exception
  // level, and at least one unmasked line is pending.
  function automatic logic int_pending(input logic       ie,
                                       input logic       exl,
                                       input logic [7:0] im,
                                       input logic [7:0] ip);
    return ie & ~exl & (|(ip & im));
  endfunction

endpackage

`default_nettype wire

// File: rtl/exc_ctrl_select.sv
// ============================================================================
// Module      : exc_select
// Description : Combinational event detection and prioritisation for the
//               instruction in WB (interrupt > exception > ERET).
// Ports       : ws_valid/ws_ex/ws_excode/ws_bd/ws_pc/ws_badvaddr/ws_eret - WB
//               instruction info; c0_status_ie/exl/im, c0_cause_ip - cp0
//               interrupt state; event_hit - WB holds an event; event_info -
//               prioritised event record to capture.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exc_select
  import exc_ctrl_pkg::*;
(
  input  logic        ws_valid,
  input  logic        ws_ex,
  input  logic [4:0]  ws_excode,
  input  logic        ws_bd,
  input  logic [31:0] ws_pc,
  input  logic [31:0] ws_badvaddr,
  input  logic        ws_eret,
  input  logic        c0_status_ie,
  input  logic        c0_status_exl,
  input  logic [7:0]  c0_status_im,
  input  logic [7:0]  c0_cause_ip,
  output logic        event_hit,
  output exc_event_t  event_info
);

  logic int_pend;

  assign int_pend  = int_pending(c0_status_ie, c0_status_exl, c0_status_im, c0_cause_ip);
  assign event_hit = ws_valid & (int_pend | ws_ex | ws_eret);

  always_comb begin
    event_info.bd       = ws_bd;
    event_info.pc       = ws_pc;
    event_info.badvaddr = ws_badvaddr;
    // An ERET that also carries an exception is handled as the exception.
    if (int_pend) begin
      event_info.kind   = EXC_KIND_INT;
      event_info.excode = EX_INT;
    end else if (ws_ex) begin
      event_info.kind   = EXC_KIND_EX;
      event_info.excode = ws_excode;
    end else begin
      event_info.kind   = EXC_KIND_ERET;
      event_info.excode = ws_excode;
    end
  end

endmodule

`default_nettype wire

// File: rtl/exc_ctrl.sv
// ============================================================================
// Module      : exc_ctrl
// Description : Exception/interrupt sequencer between WB and cp0. Stalls WB on
//               an event, issues one commit pulse to cp0, holds flush for
//               FLUSH_CYCLES cycles, then handshakes a redirect PC to fetch.
// Ports       : clk, resetn (async active-low); ws_* - WB instruction and
//               ws_ready; c0_* - cp0 status/cause/EPC; cp0_* - commit to cp0;
//               flush; redirect_valid/redirect_pc/redirect_ready - fetch.
// Config      : EXC_CTRL_STATS_EN adds exc_cnt/int_cnt/eret_cnt outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EX_VECTOR    = EXC_VECTOR,
  parameter int unsigned FLUSH_CYCLES = 2          // legal 1..15
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_valid,
  output logic        ws_ready,
  input  logic        ws_ex,
  input  logic [4:0]  ws_excode,
  input  logic        ws_bd,
  input  logic [31:0] ws_pc,
  input  logic [31:0] ws_badvaddr,
  input  logic        ws_eret,
  input  logic        c0_status_ie,
  input  logic        c0_status_exl,
  input  logic [7:0]  c0_status_im,
  input  logic [7:0]  c0_cause_ip,
  input  logic [31:0] c0_epc,
  output logic        cp0_ex,
  output logic [4:0]  cp0_excode,
  output logic        cp0_bd,
  output logic [31:0] cp0_pc,
  output logic [31:0] cp0_badvaddr,
  output logic        cp0_eret,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
`ifdef EXC_CTRL_STATS_EN
  ,
  output logic [31:0] exc_cnt,
  output logic [31:0] int_cnt,
  output logic [31:0] eret_cnt
`endif
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  logic [1:0] state;
  logic [1:0] next_state;
  logic [3:0] flush_cnt;
  logic       event_hit;
  exc_event_t event_info;
  exc_event_t cap;

  exc_select u_select (
    .ws_valid      (ws_valid),
    .ws_ex         (ws_ex),
    .ws_excode     (ws_excode),
    .ws_bd         (ws_bd),
    .ws_pc         (ws_pc),
    .ws_badvaddr   (ws_badvaddr),
    .ws_eret       (ws_eret),
    .c0_status_ie  (c0_status_ie),
    .c0_status_exl (c0_status_exl),
    .c0_status_im  (c0_status_im),
    .c0_cause_ip   (c0_cause_ip),
    .event_hit     (event_hit),
    .event_info    (event_info)
  );

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= EXC_ST_IDLE;
    else         state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      EXC_ST_IDLE:     if (event_hit) next_state = EXC_ST_COMMIT;
      EXC_ST_COMMIT:   next_state = (FLUSH_CYCLES == 1) ? EXC_ST_REDIRECT : EXC_ST_FLUSH;
      // Counter holds the remaining FLUSH cycles including this one.
      EXC_ST_FLUSH:    if (flush_cnt <= 4'd1) next_state = EXC_ST_REDIRECT;
      EXC_ST_REDIRECT: if (redirect_ready) next_state = EXC_ST_IDLE;
      default:         next_state = EXC_ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    ws_ready       = (state == EXC_ST_IDLE);
    cp0_ex         = (state == EXC_ST_COMMIT) && (cap.kind != EXC_KIND_ERET);
    cp0_eret       = (state == EXC_ST_COMMIT) && (cap.kind == EXC_KIND_ERET);
    flush          = (state == EXC_ST_COMMIT) || (state == EXC_ST_FLUSH);
    redirect_valid = (state == EXC_ST_REDIRECT);
  end

  assign cp0_excode   = cap.excode;
  assign cp0_bd       = cap.bd;
  assign cp0_pc       = cap.pc;
  assign cp0_badvaddr = cap.badvaddr;

  // Event capture happens on the retire edge only; later ws_* changes ignored.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cap <= '0;
    end else if (state == EXC_ST_IDLE && event_hit) begin
      cap <= event_info;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      flush_cnt <= 4'd0;
    end else if (state == EXC_ST_COMMIT) begin
      flush_cnt <= FLUSH_LOAD;
    end else if (state == EXC_ST_FLUSH) begin
      flush_cnt <= flush_cnt - 4'd1;
    end
  end

  // EPC is sampled on REDIRECT entry, after cp0 has absorbed the commit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      redirect_pc <= 32'd0;
    end else if (state != EXC_ST_REDIRECT && next_state == EXC_ST_REDIRECT) begin
      redirect_pc <= (cap.kind == EXC_KIND_ERET) ? c0_epc : EX_VECTOR;
    end
  end

`ifdef EXC_CTRL_STATS_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exc_cnt  <= 32'd0;
      int_cnt  <= 32'd0;
      eret_cnt <= 32'd0;
    end else if (state == EXC_ST_COMMIT) begin
      case (cap.kind)
        EXC_KIND_INT:  if (int_cnt  != 32'hffff_ffff) int_cnt  <= int_cnt  + 32'd1;
        EXC_KIND_EX:   if (exc_cnt  != 32'hffff_ffff) exc_cnt  <= exc_cnt  + 32'd1;
        EXC_KIND_ERET: if (eret_cnt != 32'hffff_ffff) eret_cnt <= eret_cnt + 32'd1;
        default: ;
      endcase
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_exc_ctrl.sv
// ============================================================================
// Module      : tb_exc_ctrl
// Description : Self-checking bench for exc_ctrl: directed scenarios plus
//               randomized events against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exc_ctrl;

  localparam int          FC  = 2;
  localparam logic [31:0] VEC = 32'hbfc0_0380;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ws_valid, ws_ready, ws_ex, ws_bd, ws_eret;
  logic [4:0]  ws_excode;
  logic [31:0] ws_pc, ws_badvaddr;
  logic        c0_status_ie, c0_status_exl;
  logic [7:0]  c0_status_im, c0_cause_ip;
  logic [31:0] c0_epc;
  logic        cp0_ex, cp0_bd, cp0_eret, flush, redirect_valid, redirect_ready;
  logic [4:0]  cp0_excode;
  logic [31:0] cp0_pc, cp0_badvaddr, redirect_pc;
`ifdef EXC_CTRL_STATS_EN
  logic [31:0] exc_cnt, int_cnt, eret_cnt;
  int          m_exc, m_int, m_eret;
`endif

  int asserts = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  exc_ctrl #(.EX_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .resetn(resetn),
    .ws_valid(ws_valid), .ws_ready(ws_ready), .ws_ex(ws_ex), .ws_excode(ws_excode),
    .ws_bd(ws_bd), .ws_pc(ws_pc), .ws_badvaddr(ws_badvaddr), .ws_eret(ws_eret),
    .c0_status_ie(c0_status_ie), .c0_status_exl(c0_status_exl),
    .c0_status_im(c0_status_im), .c0_cause_ip(c0_cause_ip), .c0_epc(c0_epc),
    .cp0_ex(cp0_ex), .cp0_excode(cp0_excode), .cp0_bd(cp0_bd), .cp0_pc(cp0_pc),
    .cp0_badvaddr(cp0_badvaddr), .cp0_eret(cp0_eret), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready)
`ifdef EXC_CTRL_STATS_EN
    , .exc_cnt(exc_cnt), .int_cnt(int_cnt), .eret_cnt(eret_cnt)
`endif
  );

  // Reference model: 0 = no event, 1 = interrupt, 2 = exception, 3 = ERET
  function automatic int model_kind(input logic ex, input logic eret, input logic ie,
                                    input logic exl, input logic [7:0] im,
                                    input logic [7:0] ip);
    bit irq;
    irq = (ie == 1'b1) && (exl == 1'b0) && ((ip & im) != 8'h00);
    if (irq)  return 1;
    if (ex)   return 2;
    if (eret) return 3;
    return 0;
  endfunction

  // Presents one instruction in WB and follows it through the whole sequence.
  task automatic run_event(input logic ex, input logic [4:0] code, input logic eret,
                           input logic bd, input logic [31:0] pc, input logic [31:0] bad,
                           input logic [31:0] epc, input logic ie, input logic exl,
                           input logic [7:0] im, input logic [7:0] ip, input int stall);
    int          kind;
    logic [4:0]  exp_code;
    logic [31:0] exp_rpc;
    ws_valid = 1'b1; ws_ex = ex; ws_excode = code; ws_eret = eret; ws_bd = bd;
    ws_pc = pc; ws_badvaddr = bad; c0_epc = epc;
    c0_status_ie = ie; c0_status_exl = exl; c0_status_im = im; c0_cause_ip = ip;
    kind     = model_kind(ex, eret, ie, exl, im, ip);
    exp_code = (kind == 1) ? 5'h00 : code;
    exp_rpc  = (kind == 3) ? epc : VEC;
    asserts++;
    if (ws_ready !== 1'b1) begin fails++; $display("FAIL ready_idle: got %b want 1", ws_ready); end
    @(posedge clk); #1;
    // Scramble WB inputs: nothing may be recaptured after the retire edge.
    ws_valid = 1'b0; ws_excode = 5'($urandom); ws_pc = $urandom; ws_bd = ~bd;
    ws_badvaddr = $urandom;
    if (kind == 0) begin
      asserts++;
      if (ws_ready !== 1'b1 || flush !== 1'b0 || cp0_ex !== 1'b0 || cp0_eret !== 1'b0 ||
          redirect_valid !== 1'b0) begin
        fails++;
        $display("FAIL no_event: ready=%b flush=%b ex=%b eret=%b rv=%b want 1 0 0 0 0",
                 ws_ready, flush, cp0_ex, cp0_eret, redirect_valid);
      end
      return;
    end
`ifdef EXC_CTRL_STATS_EN
    if (kind == 1) m_int++; else if (kind == 2) m_exc++; else m_eret++;
`endif
    asserts++;
    if (cp0_ex !== (kind != 3) || cp0_eret !== (kind == 3) || flush !== 1'b1 ||
        ws_ready !== 1'b0 || redirect_valid !== 1'b0) begin
      fails++;
      $display("FAIL commit: ex=%b eret=%b flush=%b ready=%b rv=%b kind=%0d",
               cp0_ex, cp0_eret, flush, ws_ready, redirect_valid, kind);
    end
    asserts++;
    if (cp0_excode !== exp_code || cp0_pc !== pc || cp0_bd !== bd || cp0_badvaddr !== bad) begin
      fails++;
      $display("FAIL capture: got %h/%h/%b/%h want %h/%h/%b/%h",
               cp0_excode, cp0_pc, cp0_bd, cp0_badvaddr, exp_code, pc, bd, bad);
    end
    for (int i = 1; i < FC; i++) begin
      @(posedge clk); #1;
      asserts++;
      if (flush !== 1'b1 || cp0_ex !== 1'b0 || cp0_eret !== 1'b0 || redirect_valid !== 1'b0) begin
        fails++;
        $display("FAIL flush_hold: flush=%b ex=%b eret=%b rv=%b want 1 0 0 0",
                 flush, cp0_ex, cp0_eret, redirect_valid);
      end
    end
    @(posedge clk); #1;
    asserts++;
    if (redirect_valid !== 1'b1 || flush !== 1'b0 || redirect_pc !== exp_rpc) begin
      fails++;
      $display("FAIL redirect: rv=%b flush=%b pc=%h want 1 0 %h",
               redirect_valid, flush, redirect_pc, exp_rpc);
    end
    c0_epc = $urandom;  // later EPC changes must not leak into redirect_pc
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      asserts++;
      if (redirect_valid !== 1'b1 || redirect_pc !== exp_rpc || ws_ready !== 1'b0) begin
        fails++;
        $display("FAIL redirect_stall: rv=%b pc=%h ready=%b want 1 %h 0",
                 redirect_valid, redirect_pc, ws_ready, exp_rpc);
      end
    end
    redirect_ready = 1'b1;
    @(posedge clk); #1;
    redirect_ready = 1'b0;
    asserts++;
    if (redirect_valid !== 1'b0 || ws_ready !== 1'b1 || flush !== 1'b0) begin
      fails++;
      $display("FAIL back_idle: rv=%b ready=%b flush=%b want 0 1 0",
               redirect_valid, ws_ready, flush);
    end
  endtask

  task automatic test_reset();
    asserts++;
    if (ws_ready !== 1'b1 || cp0_ex !== 1'b0 || cp0_eret !== 1'b0 || flush !== 1'b0 ||
        redirect_valid !== 1'b0 || cp0_excode !== 5'h00 || cp0_bd !== 1'b0 ||
        cp0_pc !== 32'h0 || cp0_badvaddr !== 32'h0 || redirect_pc !== 32'h0) begin
      fails++;
      $display("FAIL reset_state: ready=%b ex=%b eret=%b flush=%b rv=%b code=%h pc=%h rpc=%h",
               ws_ready, cp0_ex, cp0_eret, flush, redirect_valid, cp0_excode, cp0_pc, redirect_pc);
    end
  endtask

  task automatic test_exception();
    run_event(1'b1, 5'h04, 1'b0, 1'b0, 32'hbfc0_0100, 32'h0000_1233, 32'h0,
              1'b0, 1'b0, 8'h00, 8'h00, 0);
  endtask

  task automatic test_eret();
    run_event(1'b0, 5'h00, 1'b1, 1'b0, 32'hbfc0_0300, 32'h0, 32'hbfc0_0200,
              1'b1, 1'b1, 8'hff, 8'h00, 1);
  endtask

  task automatic test_interrupt();
    run_event(1'b0, 5'h1f, 1'b0, 1'b1, 32'hbfc0_0010, 32'h0, 32'h0,
              1'b1, 1'b0, 8'h80, 8'h80, 0);
  endtask

  task automatic test_int_masked_by_exl();
    run_event(1'b0, 5'h00, 1'b0, 1'b0, 32'hbfc0_0010, 32'h0, 32'h0,
              1'b1, 1'b1, 8'h80, 8'h80, 0);
    repeat (2) begin
      @(posedge clk); #1;
      asserts++;
      if (ws_ready !== 1'b1 || flush !== 1'b0 || redirect_valid !== 1'b0) begin
        fails++;
        $display("FAIL exl_quiet: ready=%b flush=%b rv=%b want 1 0 0",
                 ws_ready, flush, redirect_valid);
      end
    end
  endtask

  task automatic test_redirect_stall();
    // ERET carrying an exception is committed as the exception.
    run_event(1'b1, 5'h0a, 1'b1, 1'b1, 32'hbfc0_0444, 32'hdead_beef, 32'hbfc0_0200,
              1'b0, 1'b1, 8'h00, 8'h00, 5);
  endtask

  task automatic test_reset_in_flush();
    ws_valid = 1'b1; ws_ex = 1'b1; ws_eret = 1'b0; ws_excode = 5'h0c; ws_pc = 32'hbfc0_0500;
    c0_status_ie = 1'b0;
    @(posedge clk); #1;
    ws_valid = 1'b0;
    @(posedge clk); #1;
    asserts++;
    if (flush !== 1'b1) begin fails++; $display("FAIL pre_reset_flush: got %b want 1", flush); end
    resetn = 1'b0;
    #1;
    asserts++;
    if (flush !== 1'b0 || redirect_valid !== 1'b0 || cp0_ex !== 1'b0 || cp0_pc !== 32'h0) begin
      fails++;
      $display("FAIL async_reset: flush=%b rv=%b ex=%b pc=%h want 0 0 0 0",
               flush, redirect_valid, cp0_ex, cp0_pc);
    end
`ifdef EXC_CTRL_STATS_EN
    m_exc = 0; m_int = 0; m_eret = 0;
`endif
    #2;
    resetn = 1'b1;
    @(posedge clk); #1;
    asserts++;
    if (ws_ready !== 1'b1 || flush !== 1'b0 || redirect_valid !== 1'b0) begin
      fails++;
      $display("FAIL after_reset: ready=%b flush=%b rv=%b want 1 0 0",
               ws_ready, flush, redirect_valid);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_event(($urandom_range(0, 2) == 0), 5'($urandom), ($urandom_range(0, 2) == 0),
                1'($urandom), $urandom, $urandom, $urandom,
                1'($urandom), ($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom_range(0, 3)),
                $urandom_range(0, 3));
    end
  endtask

  initial begin
    resetn = 1'b0; ws_valid = 1'b0; ws_ex = 1'b0; ws_excode = 5'h0; ws_bd = 1'b0;
    ws_pc = 32'h0; ws_badvaddr = 32'h0; ws_eret = 1'b0; c0_status_ie = 1'b0;
    c0_status_exl = 1'b0; c0_status_im = 8'h0; c0_cause_ip = 8'h0; c0_epc = 32'h0;
    redirect_ready = 1'b0;
`ifdef EXC_CTRL_STATS_EN
    m_exc = 0; m_int = 0; m_eret = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    resetn = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_exception();
    test_eret();
    test_interrupt();
    test_int_masked_by_exl();
    test_redirect_stall();
    test_reset_in_flush();
    test_random();
`ifdef EXC_CTRL_STATS_EN
    asserts++;
    if (exc_cnt !== 32'(m_exc) || int_cnt !== 32'(m_int) || eret_cnt !== 32'(m_eret)) begin
      fails++;
      $display("FAIL stats: got %0d/%0d/%0d want %0d/%0d/%0d",
               exc_cnt, int_cnt, eret_cnt, m_exc, m_int, m_eret);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

`default_nettype wire
